// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

  // Width of the latency down-counter; holds LATENCY-1 for LATENCY in 1..15.
  localparam int unsigned CNT_W = 4;

  // Responder handshake states: one outstanding request at a time.
  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word storage for mem_responder: one synchronous write port and one
// combinational read port. Contents are not reset and are visible
// hierarchically as DMEM[i].
module mem_array #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 2048,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] DMEM [DEPTH];

  // Commit writes on the rising edge; no reset so contents survive rstb.
  always_ff @(posedge clk) begin
    if (we) begin
      DMEM[waddr] <= wdata;
    end
  end

  // Read port returns the pre-edge contents, so a read sampled on an edge
  // sees storage as of that edge.
  always_comb begin
    rdata = DMEM[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding request/response memory responder with a fixed
// response latency. Optional address validation is enabled by defining
// MEM_RANGE_CHECK_EN; without it, address bits [1:0] are ignored, the word
// index wraps modulo DEPTH (DEPTH assumed a power of two) and resp_err is 0.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned DEPTH   = 2048,
  parameter int unsigned LATENCY = 2
) (
  input  logic         clk,
  input  logic         rstb,
  input  logic         req_valid,
  output logic         req_ready,
  input  logic         req_we,
  input  logic [N-1:0] req_addr,
  input  logic [N-1:0] req_wdata,
  output logic         resp_valid,
  input  logic         resp_ready,
  output logic [N-1:0] resp_rdata,
  output logic         resp_err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [N-1:0]     held_rdata;
  logic             held_err;

  logic [AW-1:0]    word_idx;
  logic             req_bad;
  logic             accept;
  logic             mem_we;
  logic [N-1:0]     mem_rdata;

  assign word_idx = req_addr[AW+1:2];

`ifdef MEM_RANGE_CHECK_EN
  // Misaligned or beyond-the-array requests are flagged and never write.
  always_comb begin
    req_bad = (req_addr[1:0] != 2'b00) || ((req_addr >> 2) >= N'(DEPTH));
  end
`else
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[N-1:AW+2], req_addr[1:0]};

  // Every address is valid: the index slice wraps naturally.
  always_comb begin
    req_bad = 1'b0;
  end
`endif

  assign accept = req_valid && (state == IDLE);
  assign mem_we = accept && req_we && !req_bad;

  mem_array #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (word_idx),
    .wdata (req_wdata),
    .raddr (word_idx),
    .rdata (mem_rdata)
  );

  // Handshake FSM. The response payload is resolved at acceptance (read
  // data as of that edge, or zero for writes/invalid requests) and only
  // copied onto the outputs when entering RESP, so outputs stay zero
  // whenever resp_valid is low.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      held_rdata <= '0;
      held_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state      <= WAIT;
            cnt        <= CNT_W'(LATENCY - 1);
            req_ready  <= 1'b0;
            held_rdata <= (req_we || req_bad) ? '0 : mem_rdata;
            held_err   <= req_bad;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= held_rdata;
            resp_err   <= held_err;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          req_ready  <= 1'b1;
          resp_valid <= 1'b0;
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter N, default 32, data and address width in bits.
REQ-002 Parameter DEPTH, default 2048, number of N-bit words stored.
REQ-003 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rstb  input  1  reset, asynchronous assert, active-low.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  N  byte address.
REQ-010 req_wdata  input  N  write data.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  initiator consumes the response.
REQ-013 resp_rdata  output  N  read data; 0 for writes.
REQ-014 resp_err  output  1  request addressed an invalid location.

Function
REQ-015 The responder SHALL use states IDLE, WAIT and RESP and allow one outstanding request.
- IDLE: req_ready=1.
- WAIT and RESP: req_ready=0.
REQ-016 In IDLE, req_valid=1 SHALL cause acceptance on that rising edge: capture we, addr and wdata, load the counter with LATENCY-1, and go to WAIT.
REQ-017 In WAIT, the counter SHALL decrement each cycle; at 0 the responder SHALL go to RESP, so resp_valid first rises exactly LATENCY cycles after the acceptance edge.
REQ-018 In RESP, resp_valid=1 with stable resp_rdata and resp_err SHALL hold until a cycle with resp_ready=1, then return to IDLE.
- No new acceptance is allowed in that same cycle.
REQ-019 Word index SHALL be req_addr[log2(DEPTH)+1:2].
REQ-020 A write SHALL commit to storage on the acceptance edge.
REQ-021 A read SHALL return the storage word as of the acceptance edge.
REQ-022 resp_valid=0 SHALL force resp_rdata=0 and resp_err=0.
REQ-023 req_valid outside IDLE SHALL be ignored; the initiator holds it until it is accepted.

Reset
REQ-024 rstb=0 SHALL immediately set the state to IDLE, the counter to 0, resp_valid=0, resp_rdata=0 and resp_err=0; req_ready=1 once rstb=1.
REQ-025 Reset during WAIT or RESP SHALL discard the pending response without a retry.
- A write already accepted remains committed.
REQ-026 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-027 With MEM_RANGE_CHECK_EN defined, a request is invalid when req_addr[1:0]!=0 or the word index is >= DEPTH.
- An invalid request is accepted normally and performs no write.
- Its response carries resp_err=1 and resp_rdata=0 after the normal latency.
REQ-028 Without MEM_RANGE_CHECK_EN, the responder SHALL ignore address bits [1:0], wrap the index modulo DEPTH, and tie resp_err to 0.

Structure
REQ-029 A shared package mem_pkg SHALL hold the state type (IDLE, WAIT, RESP) and the counter width constant (4).
REQ-030 Storage SHALL be a sub-module mem_array with one synchronous write port and one read port.
- Its contents are readable hierarchically by benches as DMEM[i].

Verification
REQ-031 Write-then-read:
- Write 0xDEADBEEF to 0x10 with LATENCY=2 -> resp_valid rises 2 cycles after acceptance.
- Read 0x10 -> resp_rdata=0xDEADBEEF, resp_err=0.
REQ-032 Backpressure: hold resp_ready=0 for 5 cycles on a read -> resp_valid and resp_rdata stable throughout, req_ready=0; resp_ready=1 -> IDLE next cycle.
REQ-033 LATENCY=1 back-to-back reads of 0x0 and 0x4 with resp_ready=1 -> one response every 3 cycles with correct data.
REQ-034 Reset asserted during WAIT of a read -> resp_valid never rises, req_ready=1 after release, and a later read of that address returns the stored value.
REQ-035 MEM_RANGE_CHECK_EN defined:
- Write to 0x2002 -> resp_err=1 and DMEM unchanged.
- Write to DEPTH*4 -> resp_err=1.
- Macro undefined: write 0x55 to DEPTH*4 -> DMEM[0]=0x55.
